rf_write_sequencer: RTL and testbench

//  Initiator for the register file write port: drives WriteReg/WriteData/RegWr.
//  - Collects writeback requests from the ALU path and the multi-cycle mul/div unit (valid/ready).
//  - Queues them in order and issues at most one register write per cycle.
//  - Exports a per-register busy scoreboard so the controller can stall dependent reads.

---
 rtl/rf_wb_pkg.sv | 20 ++
 rtl/rf_write_sequencer_if.sv | 43 ++++
 rtl/rf_wb_fifo.sv | 67 ++++++
 rtl/rf_write_sequencer.sv | 134 +++++++++++++
 tb/tb_rf_write_sequencer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_wb_pkg.sv
// Shared types and widths for the register-file write sequencer.
// Optional bypass lookup is enabled with the RF_WB_BYPASS_EN macro (see rf_write_sequencer).
package rf_wb_pkg;

    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned NREG = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] rnum;
        logic [DW-1:0] data;
    } wb_entry_t;

    localparam logic [AW-1:0] REG_ZERO = '0;

    function automatic logic is_reg_zero(input logic [AW-1:0] r);
        return r == REG_ZERO;
    endfunction

endpackage

// File: rtl/rf_write_sequencer_if.sv
// Writeback request, register-file write port, scoreboard and bypass signals.
// master: requesters/controller side; slave: the sequencer.
interface rf_write_sequencer_if;
    import rf_wb_pkg::*;

    logic            alu_valid;
    logic            alu_ready;
    logic [AW-1:0]   alu_reg;
    logic [DW-1:0]   alu_data;
    logic            mdu_valid;
    logic            mdu_ready;
    logic [AW-1:0]   mdu_reg;
    logic [DW-1:0]   mdu_data;
    logic            wr_stall;
    logic            flush;
    logic [AW-1:0]   WriteReg;
    logic [DW-1:0]   WriteData;
    logic            RegWr;
    logic [NREG-1:0] busy;
    logic [AW-1:0]   count;
    logic [AW-1:0]   byp_reg;
    logic            byp_hit;
    logic [DW-1:0]   byp_data;

    modport master (
        output alu_valid, alu_reg, alu_data,
        output mdu_valid, mdu_reg, mdu_data,
        output wr_stall, flush, byp_reg,
        input  alu_ready, mdu_ready,
        input  WriteReg, WriteData, RegWr,
        input  busy, count, byp_hit, byp_data
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        input  mdu_valid, mdu_reg, mdu_data,
        input  wr_stall, flush, byp_reg,
        output alu_ready, mdu_ready,
        output WriteReg, WriteData, RegWr,
        output busy, count, byp_hit, byp_data
    );

endinterface

// File: rtl/rf_wb_fifo.sv
// Circular buffer of pending writebacks; exposes entries in age order (index 0 = head).
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_push,
    input  wb_entry_t                      i_entry,
    input  logic                           i_pop,
    input  logic                           i_flush,
    output logic [$clog2(DEPTH+1)-1:0]     o_count,
    output wb_entry_t                      o_age   [DEPTH],
    output logic [DEPTH-1:0]               o_valid
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    wb_entry_t       r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Power-of-two depth lets the pointer sum wrap naturally.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            o_age[k]   = r_mem[r_rd_ptr + PW'(k)];
            o_valid[k] = CW'(k) < r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/rf_write_sequencer.sv
// Register-file write sequencer: arbitrates ALU/MDU writebacks, queues them in order,
// issues one write per cycle and exports a busy scoreboard. Bypass lookup under RF_WB_BYPASS_EN.
module rf_write_sequencer
    import rf_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    rf_write_sequencer_if.slave  bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [CW-1:0]   w_count;
    wb_entry_t       w_age [DEPTH];
    logic [DEPTH-1:0] w_valid;
    logic            w_full;
    logic            w_empty;
    logic            w_take_mdu;
    logic            w_take_alu;
    logic            w_push;
    logic            w_pop;
    wb_entry_t       w_req;

    logic            r_regwr;
    logic [AW-1:0]   r_wreg;
    logic [DW-1:0]   r_wdata;

    logic [NREG-1:0] w_busy;
    logic            w_byp_hit;
    logic [DW-1:0]   w_byp_data;

    assign w_full  = (w_count == CW'(DEPTH));
    assign w_empty = (w_count == '0);

    // Readiness depends on occupancy only; flush drops any same-cycle request.
    assign bus.mdu_ready = !w_full && !bus.flush;
    assign bus.alu_ready = !w_full && !bus.flush && !bus.mdu_valid;

    assign w_take_mdu = bus.mdu_valid && bus.mdu_ready;
    assign w_take_alu = bus.alu_valid && bus.alu_ready;

    always_comb begin
        w_req = '0;
        if (bus.mdu_valid) begin
            w_req.rnum = bus.mdu_reg;
            w_req.data = bus.mdu_data;
        end else begin
            w_req.rnum = bus.alu_reg;
            w_req.data = bus.alu_data;
        end
    end

    // Writes to register 0 complete the handshake but are discarded here.
    assign w_push = (w_take_mdu || w_take_alu) && !is_reg_zero(w_req.rnum);
    assign w_pop  = !w_empty && !bus.wr_stall && !bus.flush;

    rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clock),
        .rst_n   (reset_n),
        .i_push  (w_push),
        .i_entry (w_req),
        .i_pop   (w_pop),
        .i_flush (bus.flush),
        .o_count (w_count),
        .o_age   (w_age),
        .o_valid (w_valid)
    );

    // Output stage: address/data hold when no write is issued.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_regwr <= 1'b0;
            r_wreg  <= '0;
            r_wdata <= '0;
        end else if (w_pop) begin
            r_regwr <= 1'b1;
            r_wreg  <= w_age[0].rnum;
            r_wdata <= w_age[0].data;
        end else begin
            r_regwr <= 1'b0;
        end
    end

    always_comb begin
        w_busy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_valid[k]) begin
                w_busy[w_age[k].rnum] = 1'b1;
            end
        end
        if (r_regwr) begin
            w_busy[r_wreg] = 1'b1;
        end
        w_busy[REG_ZERO] = 1'b0;
    end

`ifdef RF_WB_BYPASS_EN
    // Oldest first so a younger match overrides: output stage, then head to tail.
    always_comb begin
        w_byp_hit  = 1'b0;
        w_byp_data = '0;
        if (r_regwr && r_wreg == bus.byp_reg) begin
            w_byp_hit  = 1'b1;
            w_byp_data = r_wdata;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (w_valid[k] && w_age[k].rnum == bus.byp_reg) begin
                w_byp_hit  = 1'b1;
                w_byp_data = w_age[k].data;
            end
        end
        if (is_reg_zero(bus.byp_reg)) begin
            w_byp_hit  = 1'b0;
            w_byp_data = '0;
        end
    end
`else
    logic w_unused_byp;
    assign w_unused_byp = ^bus.byp_reg;
    assign w_byp_hit    = 1'b0;
    assign w_byp_data   = '0;
`endif

    assign bus.RegWr     = r_regwr;
    assign bus.WriteReg  = r_wreg;
    assign bus.WriteData = r_wdata;
    assign bus.busy      = w_busy;
    assign bus.count     = AW'(w_count);
    assign bus.byp_hit   = w_byp_hit;
    assign bus.byp_data  = w_byp_data;

endmodule

// File: tb/tb_rf_write_sequencer.sv
// Directed and random checks of rf_write_sequencer against a queue-based reference model.
module tb_rf_write_sequencer;
    import rf_wb_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    rf_write_sequencer_if bus();

    rf_write_sequencer #(.DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Reference model: pending writes in acceptance order plus the issued write.
    wb_entry_t       q[$];
    logic            m_regwr;
    logic [AW-1:0]   m_wreg;
    logic [DW-1:0]   m_wdata;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREG-1:0] model_busy();
        logic [NREG-1:0] b;
        b = '0;
        foreach (q[i]) if (q[i].rnum != 0) b[q[i].rnum] = 1'b1;
        if (m_regwr && m_wreg != 0) b[m_wreg] = 1'b1;
        return b;
    endfunction

    task automatic model_byp(input logic [AW-1:0] r, output logic hit, output logic [DW-1:0] data);
        hit  = 1'b0;
        data = '0;
`ifdef RF_WB_BYPASS_EN
        if (r != 0) begin
            for (int i = q.size() - 1; i >= 0 && !hit; i--) begin
                if (q[i].rnum == r) begin
                    hit  = 1'b1;
                    data = q[i].data;
                end
            end
            if (!hit && m_regwr && m_wreg == r) begin
                hit  = 1'b1;
                data = m_wdata;
            end
        end
`endif
    endtask

    task automatic check_outputs(input string tag);
        logic          eh;
        logic [DW-1:0] ed;
        model_byp(bus.byp_reg, eh, ed);
        chk({tag, ".RegWr"},     64'(bus.RegWr),     64'(m_regwr));
        chk({tag, ".WriteReg"},  64'(bus.WriteReg),  64'(m_wreg));
        chk({tag, ".WriteData"}, 64'(bus.WriteData), 64'(m_wdata));
        chk({tag, ".count"},     64'(bus.count),     64'(q.size()));
        chk({tag, ".busy"},      64'(bus.busy),      64'(model_busy()));
        chk({tag, ".byp_hit"},   64'(bus.byp_hit),   64'(eh));
        chk({tag, ".byp_data"},  64'(bus.byp_data),  64'(ed));
    endtask

    // One clock: check readies mid-cycle, advance the model at the edge, check state after it.
    task automatic cycle(input string tag);
        bit        room, take, fl, st;
        wb_entry_t e;
        @(negedge clock);
        room = (q.size() < DEPTH) && !bus.flush;
        chk({tag, ".mdu_ready"}, 64'(bus.mdu_ready), 64'(room));
        chk({tag, ".alu_ready"}, 64'(bus.alu_ready), 64'(room && !bus.mdu_valid));
        take = room && (bus.mdu_valid || bus.alu_valid);
        e.rnum = bus.mdu_valid ? bus.mdu_reg  : bus.alu_reg;
        e.data = bus.mdu_valid ? bus.mdu_data : bus.alu_data;
        fl = bus.flush;
        st = bus.wr_stall;
        @(posedge clock);
        #1;
        if (fl) begin
            q.delete();
            m_regwr = 1'b0;
        end else begin
            if (q.size() > 0 && !st) begin
                wb_entry_t h;
                h       = q.pop_front();
                m_regwr = 1'b1;
                m_wreg  = h.rnum;
                m_wdata = h.data;
            end else begin
                m_regwr = 1'b0;
            end
            if (take && e.rnum != 0) q.push_back(e);
        end
        check_outputs(tag);
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.mdu_valid = 1'b0;
        bus.wr_stall  = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic alu(input logic [AW-1:0] r, input logic [DW-1:0] d);
        bus.alu_valid = 1'b1;
        bus.alu_reg   = r;
        bus.alu_data  = d;
    endtask

    task automatic model_reset();
        q.delete();
        m_regwr = 1'b0;
        m_wreg  = '0;
        m_wdata = '0;
    endtask

    initial begin
        idle();
        bus.alu_reg = '0; bus.alu_data = '0;
        bus.mdu_reg = '0; bus.mdu_data = '0;
        bus.byp_reg = '0;
        model_reset();
        reset_n = 1'b0;
        #12;
        check_outputs("reset");
        reset_n = 1'b1;
        @(posedge clock); #1;

        // 1: single ALU write appears one cycle after acceptance
        alu(5'd3, 32'h11);
        cycle("t1.acc");
        idle();
        cycle("t1.issue");
        chk("t1.regwr_const", 64'(bus.RegWr), 64'd1);
        chk("t1.wreg_const",  64'(bus.WriteReg), 64'd3);
        chk("t1.busy3", 64'(bus.busy[3]), 64'd1);
        cycle("t1.after");
        chk("t1.busy3_clear", 64'(bus.busy[3]), 64'd0);

        // 2: MDU wins over ALU, writes stay in acceptance order
        alu(5'd5, 32'hA);
        bus.mdu_valid = 1'b1; bus.mdu_reg = 5'd6; bus.mdu_data = 32'hB;
        cycle("t2.both");
        bus.mdu_valid = 1'b0;
        cycle("t2.alu");
        chk("t2.first_reg", 64'(bus.WriteReg), 64'd6);
        idle();
        cycle("t2.second");
        chk("t2.second_reg", 64'(bus.WriteReg), 64'd5);
        cycle("t2.drain");

        // 3: fill under stall, fifth request held until space frees
        bus.wr_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alu(AW'(8 + i), DW'(32'h100 + i));
            cycle("t3.fill");
        end
        alu(5'd12, 32'h104);
        cycle("t3.full");
        chk("t3.count4", 64'(bus.count), 64'd4);
        bus.wr_stall = 1'b0;
        cycle("t3.rel0");
        cycle("t3.rel1");
        bus.alu_valid = 1'b0;
        for (int i = 0; i < 5; i++) cycle("t3.drain");

        // 4: register 0 handshakes but is never queued or written
        alu(5'd0, 32'hFF);
        cycle("t4.push0");
        chk("t4.count0", 64'(bus.count), 64'd0);
        idle();
        cycle("t4.idle0");
        cycle("t4.idle1");

        // 5: bypass returns the youngest pending write to reg 7
        bus.wr_stall = 1'b1;
        alu(5'd7, 32'h1);
        cycle("t5.p1");
        alu(5'd7, 32'h2);
        bus.byp_reg = 5'd7;
        cycle("t5.p2");
`ifdef RF_WB_BYPASS_EN
        chk("t5.hit_const",  64'(bus.byp_hit),  64'd1);
        chk("t5.data_const", 64'(bus.byp_data), 64'h2);
`else
        chk("t5.hit_const",  64'(bus.byp_hit),  64'd0);
`endif
        idle();
        for (int i = 0; i < 3; i++) cycle("t5.drain");

        // 6a: flush empties the queue and suppresses the write
        bus.wr_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu(AW'(20 + i), DW'(32'h200 + i));
            cycle("t6.fill");
        end
        bus.alu_valid = 1'b0;
        bus.flush = 1'b1;
        alu(5'd25, 32'h333);
        cycle("t6.flush");
        chk("t6.count_const", 64'(bus.count), 64'd0);
        chk("t6.busy_const",  64'(bus.busy),  64'd0);
        idle();
        cycle("t6.post");

        // 6b: asynchronous reset mid-operation
        bus.wr_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu(AW'(24 + i), DW'(32'h300 + i));
            cycle("t6r.fill");
        end
        bus.wr_stall = 1'b0;
        bus.alu_valid = 1'b0;
        cycle("t6r.issue");
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs("t6r.async");
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check_outputs("t6r.released");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            bus.alu_valid = ($urandom_range(0, 99) < 60);
            bus.mdu_valid = ($urandom_range(0, 99) < 30);
            bus.alu_reg   = AW'($urandom_range(0, 7));
            bus.mdu_reg   = AW'($urandom_range(0, 7));
            bus.alu_data  = DW'($urandom);
            bus.mdu_data  = DW'($urandom);
            bus.wr_stall  = ($urandom_range(0, 99) < 35);
            bus.flush     = ($urandom_range(0, 99) < 4);
            bus.byp_reg   = AW'($urandom_range(0, 7));
            cycle("rand");
        end
        idle();
        for (int i = 0; i < 6; i++) cycle("rand.drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
